// File: rtl/trigger_sequencer_if.sv
// Command, control, sample and status signals of the trigger sequencer; master drives, slave is the sequencer.
// Everything is sampled on the sequencer clock; nothing here carries backpressure.
interface trigger_sequencer_if #(
  parameter int CHANNELS = 8
);
  logic                cmd_valid;
  logic [7:0]          cmd_command;
  logic [31:0]         cmd_param;
  logic                arm;
  logic                abort;
  logic                sample_valid;
  logic [CHANNELS-1:0] channels;
  logic                armed;
  logic                triggered;
  logic [1:0]          stage;

  modport master (
    output cmd_valid, cmd_command, cmd_param, arm, abort, sample_valid, channels,
    input  armed, triggered, stage
  );

  modport slave (
    input  cmd_valid, cmd_command, cmd_param, arm, abort, sample_valid, channels,
    output armed, triggered, stage
  );
endinterface

// File: rtl/trigger_sequencer.sv
// 4-stage serial trigger: decodes 0xC0-0xCF setup commands, steps stages on sample_valid, pulses triggered.
// Edge terms are built only with TRIGGER_SEQUENCER_EDGE_EN; triggered lags the completing stage by 1 cycle; no backpressure.
module trigger_sequencer #(
  parameter int CHANNELS    = 8,
  parameter int STAGES      = 4,
  parameter int DELAY_WIDTH = 16
) (
  input logic                clock,
  input logic                reset_n,
  trigger_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MATCH = 2'd1,
    S_DELAY = 2'd2,
    S_FIRED = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic [STAGES-1:0][CHANNELS-1:0]    mask_q, mask_d;
  logic [STAGES-1:0][CHANNELS-1:0]    value_q, value_d;
  logic [STAGES-1:0][DELAY_WIDTH-1:0] delay_q, delay_d;
  logic [STAGES-1:0]                  start_q, start_d;
`ifdef TRIGGER_SEQUENCER_EDGE_EN
  logic [STAGES-1:0][CHANNELS-1:0]    edge_q, edge_d;
  logic [CHANNELS-1:0]                prev_q, prev_d;
  logic                               prev_valid_q, prev_valid_d;
`endif
  logic [1:0]                         stage_q, stage_d;
  logic [DELAY_WIDTH-1:0]             cnt_q, cnt_d;
  logic                               triggered_q, triggered_d;

  logic       cmd_reset;
  logic       cmd_cfg;
  logic [1:0] cmd_stage;
  logic       armed;
  logic       level_hit;
  logic       edge_hit;
  logic       stage_hit;
  logic       cnt_done;
  logic       unused_param_bits;

  // Only some parameter bits are meaningful; the rest are deliberately dropped.
  assign unused_param_bits = ^bus.cmd_param;

  assign cmd_reset = bus.cmd_valid && (bus.cmd_command == 8'h00);
  assign cmd_cfg   = bus.cmd_valid && (bus.cmd_command[7:4] == 4'hC) &&
                     ((state_q == S_IDLE) || (state_q == S_FIRED));
  assign cmd_stage = bus.cmd_command[3:2];
  assign armed     = (state_q == S_MATCH) || (state_q == S_DELAY);

  assign level_hit = ((bus.channels ^ value_q[stage_q]) & mask_q[stage_q]) == '0;
`ifdef TRIGGER_SEQUENCER_EDGE_EN
  // Without a previous sample only a stage with no edge requirement can match.
  assign edge_hit  = prev_valid_q ?
                     ((edge_q[stage_q] & (bus.channels ^ prev_q)) == edge_q[stage_q]) :
                     (edge_q[stage_q] == '0);
`else
  assign edge_hit  = 1'b1;
`endif
  assign stage_hit = level_hit && edge_hit;

  // A zero count completes at once; otherwise completion is the strobe that takes it to zero.
  assign cnt_done  = (cnt_q == '0) || (bus.sample_valid && (cnt_q == DELAY_WIDTH'(1)));

  always_comb begin
    state_d     = state_q;
    stage_d     = stage_q;
    cnt_d       = cnt_q;
    triggered_d = 1'b0;
    mask_d      = mask_q;
    value_d     = value_q;
    delay_d     = delay_q;
    start_d     = start_q;
`ifdef TRIGGER_SEQUENCER_EDGE_EN
    edge_d       = edge_q;
    prev_d       = prev_q;
    prev_valid_d = prev_valid_q;
    if (armed && bus.sample_valid) begin
      prev_d       = bus.channels;
      prev_valid_d = 1'b1;
    end
`endif

    case (state_q)
      S_IDLE, S_FIRED: begin
        if (bus.arm) begin
          state_d = S_MATCH;
          stage_d = 2'd0;
`ifdef TRIGGER_SEQUENCER_EDGE_EN
          prev_valid_d = 1'b0;
`endif
        end
      end
      S_MATCH: begin
        if (bus.sample_valid && stage_hit) begin
          state_d = S_DELAY;
          cnt_d   = delay_q[stage_q];
        end
      end
      S_DELAY: begin
        if (cnt_done) begin
          cnt_d = '0;
          if (start_q[stage_q] || (stage_q == 2'd3)) begin
            triggered_d = 1'b1;
            state_d     = S_FIRED;
          end else begin
            stage_d = stage_q + 2'd1;
            state_d = S_MATCH;
          end
        end else if (bus.sample_valid) begin
          cnt_d = cnt_q - DELAY_WIDTH'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (cmd_cfg) begin
      case (bus.cmd_command[1:0])
        2'd0: mask_d[cmd_stage]  = bus.cmd_param[CHANNELS-1:0];
        2'd1: value_d[cmd_stage] = bus.cmd_param[CHANNELS-1:0];
        2'd2: begin
          delay_d[cmd_stage] = bus.cmd_param[DELAY_WIDTH-1:0];
          start_d[cmd_stage] = bus.cmd_param[27];
        end
`ifdef TRIGGER_SEQUENCER_EDGE_EN
        2'd3: edge_d[cmd_stage]  = bus.cmd_param[CHANNELS-1:0];
`endif
        default: ;
      endcase
    end

    // Abort and the reset command override any transition, including a pending trigger.
    if (bus.abort || cmd_reset) begin
      state_d     = S_IDLE;
      stage_d     = 2'd0;
      cnt_d       = '0;
      triggered_d = 1'b0;
    end

    if (cmd_reset) begin
      mask_d  = '0;
      value_d = '0;
      delay_d = '0;
      start_d = '0;
`ifdef TRIGGER_SEQUENCER_EDGE_EN
      edge_d  = '0;
`endif
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      stage_q     <= 2'd0;
      cnt_q       <= '0;
      triggered_q <= 1'b0;
      mask_q      <= '0;
      value_q     <= '0;
      delay_q     <= '0;
      start_q     <= '0;
`ifdef TRIGGER_SEQUENCER_EDGE_EN
      edge_q       <= '0;
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      stage_q     <= stage_d;
      cnt_q       <= cnt_d;
      triggered_q <= triggered_d;
      mask_q      <= mask_d;
      value_q     <= value_d;
      delay_q     <= delay_d;
      start_q     <= start_d;
`ifdef TRIGGER_SEQUENCER_EDGE_EN
      edge_q       <= edge_d;
      prev_q       <= prev_d;
      prev_valid_q <= prev_valid_d;
`endif
    end
  end

  assign bus.armed     = armed;
  assign bus.triggered = triggered_q;
  assign bus.stage     = stage_q;

endmodule

// File: tb/tb_trigger_sequencer.sv
// Directed bench for trigger_sequencer: per-scenario tasks with hand-derived expectations.
module tb_trigger_sequencer;

  logic clock;
  logic reset_n;
  int   checks;
  int   failures;
  int   trig_cnt;

  localparam logic [31:0] START = 32'h0800_0000;

  trigger_sequencer_if #(.CHANNELS(8)) bus ();

  trigger_sequencer #(.CHANNELS(8), .STAGES(4), .DELAY_WIDTH(16)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) if (bus.triggered === 1'b1) trig_cnt <= trig_cnt + 1;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_cmd(input logic [7:0] c, input logic [31:0] p);
    bus.cmd_valid   = 1'b1;
    bus.cmd_command = c;
    bus.cmd_param   = p;
    tick();
    bus.cmd_valid   = 1'b0;
  endtask

  task automatic pulse_arm();
    bus.arm = 1'b1;
    tick();
    bus.arm = 1'b0;
  endtask

  task automatic pulse_abort();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
  endtask

  task automatic sample(input logic [7:0] ch);
    bus.channels     = ch;
    bus.sample_valid = 1'b1;
    tick();
    bus.sample_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #2;
    checks++; if (bus.armed !== 1'b0) begin failures++; $display("FAIL reset_armed got=%0b exp=0", bus.armed); end
    checks++; if (bus.triggered !== 1'b0) begin failures++; $display("FAIL reset_triggered got=%0b exp=0", bus.triggered); end
    checks++; if (bus.stage !== 2'd0) begin failures++; $display("FAIL reset_stage got=%0d exp=0", bus.stage); end
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    int t0;
    send_cmd(8'h00, 32'h0);
    send_cmd(8'hC0, 32'hFF);
    send_cmd(8'hC1, 32'hA5);
    send_cmd(8'hC2, START);
    t0 = trig_cnt;
    pulse_arm();
    checks++; if (bus.armed !== 1'b1) begin failures++; $display("FAIL single_armed got=%0b exp=1", bus.armed); end
    sample(8'h00); tick();
    sample(8'h12); tick();
    sample(8'hA5);
    checks++; if (bus.triggered !== 1'b0) begin failures++; $display("FAIL single_trig_early got=%0b exp=0", bus.triggered); end
    tick();
    checks++; if (bus.triggered !== 1'b1) begin failures++; $display("FAIL single_trig got=%0b exp=1", bus.triggered); end
    checks++; if (bus.armed !== 1'b0) begin failures++; $display("FAIL single_armed_fall got=%0b exp=0", bus.armed); end
    checks++; if (bus.stage !== 2'd0) begin failures++; $display("FAIL single_stage got=%0d exp=0", bus.stage); end
    tick();
    checks++; if (bus.triggered !== 1'b0) begin failures++; $display("FAIL single_pulse_width got=%0b exp=0", bus.triggered); end
    tick();
    checks++; if (trig_cnt - t0 !== 1) begin failures++; $display("FAIL single_count got=%0d exp=1", trig_cnt - t0); end
  endtask

  task automatic test_sequential();
    int t0;
    send_cmd(8'h00, 32'h0);
    send_cmd(8'hC0, 32'h01);
    send_cmd(8'hC1, 32'h01);
    send_cmd(8'hC4, 32'h02);
    send_cmd(8'hC5, 32'h02);
    send_cmd(8'hC6, START);
    t0 = trig_cnt;
    pulse_arm();
    sample(8'h02); tick();
    checks++; if (bus.stage !== 2'd0) begin failures++; $display("FAIL seq_stage0 got=%0d exp=0", bus.stage); end
    sample(8'h01); tick();
    checks++; if (bus.stage !== 2'd1) begin failures++; $display("FAIL seq_stage1 got=%0d exp=1", bus.stage); end
    pulse_arm();
    checks++; if (bus.stage !== 2'd1) begin failures++; $display("FAIL seq_rearm_ignored got=%0d exp=1", bus.stage); end
    send_cmd(8'hC4, 32'h00);
    sample(8'h00); tick(); tick();
    checks++; if (trig_cnt - t0 !== 0) begin failures++; $display("FAIL seq_cfg_locked got=%0d exp=0", trig_cnt - t0); end
    checks++; if (bus.armed !== 1'b1) begin failures++; $display("FAIL seq_still_armed got=%0b exp=1", bus.armed); end
    sample(8'h02); tick();
    checks++; if (bus.triggered !== 1'b1) begin failures++; $display("FAIL seq_trig got=%0b exp=1", bus.triggered); end
    tick();
    checks++; if (trig_cnt - t0 !== 1) begin failures++; $display("FAIL seq_count got=%0d exp=1", trig_cnt - t0); end
  endtask

  task automatic test_delay();
    send_cmd(8'h00, 32'h0);
    send_cmd(8'hC2, START | 32'd5);
    pulse_arm();
    sample(8'h00);
    for (int i = 1; i <= 5; i++) begin
      sample(8'h00);
      if (i == 4) begin
        checks++; if (bus.triggered !== 1'b0) begin failures++; $display("FAIL delay_early got=%0b exp=0", bus.triggered); end
        checks++; if (bus.armed !== 1'b1) begin failures++; $display("FAIL delay_armed got=%0b exp=1", bus.armed); end
      end
    end
    checks++; if (bus.triggered !== 1'b1) begin failures++; $display("FAIL delay_trig got=%0b exp=1", bus.triggered); end
    tick();
    checks++; if (bus.triggered !== 1'b0) begin failures++; $display("FAIL delay_pulse_width got=%0b exp=0", bus.triggered); end
  endtask

  task automatic test_edge();
    int t0;
    send_cmd(8'h00, 32'h0);
    send_cmd(8'hC3, 32'h08);
    send_cmd(8'hC0, 32'h08);
    send_cmd(8'hC1, 32'h08);
    send_cmd(8'hC2, START);
    t0 = trig_cnt;
    pulse_arm();
`ifdef TRIGGER_SEQUENCER_EDGE_EN
    sample(8'h08); tick(); tick();
    checks++; if (trig_cnt - t0 !== 0) begin failures++; $display("FAIL edge_first_sample got=%0d exp=0", trig_cnt - t0); end
    sample(8'h00); tick(); tick();
    checks++; if (bus.armed !== 1'b1) begin failures++; $display("FAIL edge_armed got=%0b exp=1", bus.armed); end
    sample(8'h08); tick();
    checks++; if (bus.triggered !== 1'b1) begin failures++; $display("FAIL edge_trig got=%0b exp=1", bus.triggered); end
`else
    sample(8'h08); tick();
    checks++; if (bus.triggered !== 1'b1) begin failures++; $display("FAIL edge_off_trig got=%0b exp=1", bus.triggered); end
`endif
    tick();
    checks++; if (trig_cnt - t0 !== 1) begin failures++; $display("FAIL edge_count got=%0d exp=1", trig_cnt - t0); end
  endtask

  task automatic test_abort();
    int t0;
    send_cmd(8'h00, 32'h0);
    send_cmd(8'hC6, START | 32'd100);
    t0 = trig_cnt;
    pulse_arm();
    sample(8'h00); tick();
    sample(8'h00);
    for (int i = 0; i < 60; i++) sample(8'h00);
    checks++; if (bus.stage !== 2'd1) begin failures++; $display("FAIL abort_pre_stage got=%0d exp=1", bus.stage); end
    checks++; if (bus.armed !== 1'b1) begin failures++; $display("FAIL abort_pre_armed got=%0b exp=1", bus.armed); end
    pulse_abort();
    checks++; if (bus.armed !== 1'b0) begin failures++; $display("FAIL abort_armed got=%0b exp=0", bus.armed); end
    checks++; if (bus.stage !== 2'd0) begin failures++; $display("FAIL abort_stage got=%0d exp=0", bus.stage); end
    for (int i = 0; i < 45; i++) sample(8'h00);
    checks++; if (trig_cnt - t0 !== 0) begin failures++; $display("FAIL abort_no_trig got=%0d exp=0", trig_cnt - t0); end
    pulse_arm();
    checks++; if (bus.armed !== 1'b1) begin failures++; $display("FAIL abort_rearm got=%0b exp=1", bus.armed); end
    checks++; if (bus.stage !== 2'd0) begin failures++; $display("FAIL abort_rearm_stage got=%0d exp=0", bus.stage); end
    sample(8'h00); tick();
    send_cmd(8'h00, 32'h0);
    checks++; if (bus.armed !== 1'b0) begin failures++; $display("FAIL rstcmd_armed got=%0b exp=0", bus.armed); end
    checks++; if (bus.stage !== 2'd0) begin failures++; $display("FAIL rstcmd_stage got=%0d exp=0", bus.stage); end
  endtask

  task automatic test_back_to_back();
    int t0;
    send_cmd(8'h00, 32'h0);
    send_cmd(8'hC2, START);
    t0 = trig_cnt;
    pulse_arm();
    sample(8'h00);
    pulse_abort();
    checks++; if (bus.triggered !== 1'b0) begin failures++; $display("FAIL b2b_abort_trig got=%0b exp=0", bus.triggered); end
    checks++; if (bus.armed !== 1'b0) begin failures++; $display("FAIL b2b_abort_armed got=%0b exp=0", bus.armed); end
    tick();
    checks++; if (trig_cnt - t0 !== 0) begin failures++; $display("FAIL b2b_count got=%0d exp=0", trig_cnt - t0); end
  endtask

  task automatic test_async_reset();
    int t0;
    send_cmd(8'h00, 32'h0);
    send_cmd(8'hC0, 32'hFF);
    send_cmd(8'hC1, 32'h5A);
    send_cmd(8'hC4, 32'hFF);
    send_cmd(8'hC5, 32'h5A);
    send_cmd(8'hC6, START);
    pulse_arm();
    sample(8'h5A); tick();
    checks++; if (bus.stage !== 2'd1) begin failures++; $display("FAIL areset_pre_stage got=%0d exp=1", bus.stage); end
    bus.channels     = 8'h5A;
    bus.sample_valid = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (bus.armed !== 1'b0) begin failures++; $display("FAIL areset_armed got=%0b exp=0", bus.armed); end
    checks++; if (bus.stage !== 2'd0) begin failures++; $display("FAIL areset_stage got=%0d exp=0", bus.stage); end
    checks++; if (bus.triggered !== 1'b0) begin failures++; $display("FAIL areset_trig got=%0b exp=0", bus.triggered); end
    bus.sample_valid = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    t0 = trig_cnt;
    pulse_arm();
    sample(8'h00); tick();
    checks++; if (bus.stage !== 2'd1) begin failures++; $display("FAIL areset_cleared got=%0d exp=1", bus.stage); end
    sample(8'h00); tick();
    sample(8'h00); tick();
    sample(8'h00); tick();
    checks++; if (bus.triggered !== 1'b1) begin failures++; $display("FAIL areset_last_stage_trig got=%0b exp=1", bus.triggered); end
    checks++; if (bus.stage !== 2'd3) begin failures++; $display("FAIL areset_final_stage got=%0d exp=3", bus.stage); end
    tick();
    checks++; if (trig_cnt - t0 !== 1) begin failures++; $display("FAIL areset_count got=%0d exp=1", trig_cnt - t0); end
  endtask

  initial begin
    checks           = 0;
    failures         = 0;
    trig_cnt         = 0;
    reset_n          = 1'b0;
    bus.cmd_valid    = 1'b0;
    bus.cmd_command  = 8'h00;
    bus.cmd_param    = 32'h0;
    bus.arm          = 1'b0;
    bus.abort        = 1'b0;
    bus.sample_valid = 1'b0;
    bus.channels     = 8'h00;
    test_reset();
    test_single();
    test_sequential();
    test_delay();
    test_edge();
    test_abort();
    test_back_to_back();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
